// File: rtl/biquad_ff_mac.sv
// Feed-forward half of a biquad: strobes the upstream sample shift register, then
// accumulates b0*fk + b1*fk_1 + b2*fk_2 through one shared multiplier and saturates.
module biquad_ff_mac #(
  parameter int N    = 25,
  parameter int FRAC = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sample_valid,
  input  logic signed [N-1:0]   b0,
  input  logic signed [N-1:0]   b1,
  input  logic signed [N-1:0]   b2,
  input  logic signed [2*N-1:0] fk,
  input  logic signed [2*N-1:0] fk_1,
  input  logic signed [2*N-1:0] fk_2,
  output logic                  shift,
  output logic signed [2*N-1:0] y,
  output logic                  y_valid,
  output logic                  busy,
  output logic                  sat,
  output logic                  overrun
);

  localparam int TW = 2 * N;
  localparam int PW = 3 * N;
  localparam int AW = 3 * N + 2;

  typedef enum logic [2:0] {IDLE, SHIFT, MAC0, MAC1, MAC2, DONE} state_t;

  state_t               state;
  logic                 pending;
  logic signed [N-1:0]  b0_q;
  logic signed [N-1:0]  b1_q;
  logic signed [N-1:0]  b2_q;
  logic signed [AW-1:0] acc;

  logic signed [N-1:0]  coef_sel;
  logic signed [TW-1:0] tap_sel;
  logic signed [PW-1:0] product;
  logic signed [AW-1:0] acc_next;
  logic signed [AW-1:0] scaled;
  logic signed [TW-1:0] y_sat;
  logic                 clip;

  // One multiplier is time-shared; the state picks which coefficient/tap pair it sees.
  always_comb begin
    coef_sel = b0_q;
    tap_sel  = fk;
    case (state)
      MAC1: begin
        coef_sel = b1_q;
        tap_sel  = fk_1;
      end
      MAC2: begin
        coef_sel = b2_q;
        tap_sel  = fk_2;
      end
      default: ;
    endcase
  end

  assign product  = PW'(coef_sel) * PW'(tap_sel);
  assign acc_next = acc + AW'(product);
  assign scaled   = acc >>> FRAC;
  assign busy     = (state != IDLE);

  // Any upper bit disagreeing with the sign means the scaled sum no longer fits in y.
  always_comb begin
    clip  = 1'b0;
    y_sat = scaled[TW-1:0];
    if (scaled[AW-1:TW-1] != {(AW-TW+1){scaled[AW-1]}}) begin
      clip  = 1'b1;
      y_sat = scaled[AW-1] ? {1'b1, {(TW-1){1'b0}}} : {1'b0, {(TW-1){1'b1}}};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      shift   <= 1'b0;
      y       <= '0;
      y_valid <= 1'b0;
      sat     <= 1'b0;
      overrun <= 1'b0;
      pending <= 1'b0;
      acc     <= '0;
      b0_q    <= '0;
      b1_q    <= '0;
      b2_q    <= '0;
    end else begin
      y_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (sample_valid || pending) begin
            state   <= SHIFT;
            shift   <= 1'b1;
            // A fresh strobe landing on the cycle a queued one is serviced stays queued.
            pending <= sample_valid && pending;
            b0_q    <= b0;
            b1_q    <= b1;
            b2_q    <= b2;
          end
        end
        SHIFT: begin
          shift <= 1'b0;
          acc   <= '0;
          state <= MAC0;
        end
        MAC0: begin
          acc   <= acc_next;
          state <= MAC1;
        end
        MAC1: begin
          acc   <= acc_next;
          state <= MAC2;
        end
        MAC2: begin
          acc   <= acc_next;
          state <= DONE;
        end
        DONE: begin
          y       <= y_sat;
          y_valid <= 1'b1;
          if (clip) sat <= 1'b1;
          state   <= IDLE;
        end
        default: begin
          shift <= 1'b0;
          state <= IDLE;
        end
      endcase
      if (sample_valid && (state != IDLE)) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end
    end
  end

endmodule
